mac8_seq_controller: RTL

MAC8_SEQ_CONTROLLER -- requirements
Module: mac8_seq_controller

---
 rtl/mac8_seq_controller.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mac8_seq_controller.sv
// Sequential 8x8 unsigned multiply-accumulate built around one shared 4x4 vedic multiplier.
// Each operation spends four cycles on partial products and one cycle on accumulation.

module vedic_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic t1, t2, c1, t3;

  assign t1   = a[1] & b[0];
  assign t2   = a[0] & b[1];
  assign t3   = a[1] & b[1];
  assign c1   = t1 & t2;
  assign p[0] = a[0] & b[0];
  assign p[1] = t1 ^ t2;
  assign p[2] = t3 ^ c1;
  assign p[3] = t3 & c1;
endmodule

module vedic_4bit_multiplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] q0, q1, q2, q3;

  vedic_2x2 u_q0 (.a(a[1:0]), .b(b[1:0]), .p(q0));
  vedic_2x2 u_q1 (.a(a[3:2]), .b(b[1:0]), .p(q1));
  vedic_2x2 u_q2 (.a(a[1:0]), .b(b[3:2]), .p(q2));
  vedic_2x2 u_q3 (.a(a[3:2]), .b(b[3:2]), .p(q3));

  // Cross terms share weight 4; the high product sits at weight 16.
  assign p = {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
endmodule

// state | meaning
// IDLE  | ready for an operand pair; out_valid marks the first IDLE cycle after ACC
// MUL   | four phases, one 4x4 partial product folded into psum per cycle
// ACC   | publish product, update acc and sticky carry flag
module mac8_seq_controller #(
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic             in_clr,
  output logic             out_valid,
  output logic [15:0]      product,
  output logic [ACC_W-1:0] acc,
  output logic             acc_ovf
);
  typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

  state_t           state;
  logic [1:0]       phase;
  logic [7:0]       a_r, b_r;
  logic             clr_r;
  logic [15:0]      psum;
  logic [3:0]       mul_a, mul_b;
  logic [7:0]       pp;
  logic [15:0]      pp_shift;
  logic [15:0]      psum_next;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W:0]   acc_sum;

  vedic_4bit_multiplier u_mul (.a(mul_a), .b(mul_b), .p(pp));

  always_comb begin
    mul_a    = a_r[3:0];
    mul_b    = b_r[3:0];
    pp_shift = {8'b0, pp};
    case (phase)
      2'd0: begin mul_a = a_r[3:0]; mul_b = b_r[3:0]; pp_shift = {8'b0, pp};       end
      2'd1: begin mul_a = a_r[3:0]; mul_b = b_r[7:4]; pp_shift = {4'b0, pp, 4'b0}; end
      2'd2: begin mul_a = a_r[7:4]; mul_b = b_r[3:0]; pp_shift = {4'b0, pp, 4'b0}; end
      default: begin mul_a = a_r[7:4]; mul_b = b_r[7:4]; pp_shift = {pp, 8'b0};    end
    endcase
  end

  // Four partial products of 8-bit operands never exceed 0xFE01, so no carry is lost.
  assign psum_next = psum + pp_shift;
  assign acc_base  = clr_r ? '0 : acc;
  assign acc_sum   = {1'b0, acc_base} + {{(ACC_W-15){1'b0}}, psum};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase     <= 2'd0;
      psum      <= 16'd0;
      a_r       <= 8'd0;
      b_r       <= 8'd0;
      clr_r     <= 1'b0;
      product   <= 16'd0;
      acc       <= '0;
      acc_ovf   <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            clr_r    <= in_clr;
            psum     <= 16'd0;
            phase    <= 2'd0;
            state    <= MUL;
            in_ready <= 1'b0;
          end
        end
        MUL: begin
          psum  <= psum_next;
          phase <= phase + 2'd1;
          if (phase == 2'd3) state <= ACC;
        end
        ACC: begin
          product   <= psum;
          acc       <= acc_sum[ACC_W-1:0];
          acc_ovf   <= clr_r ? acc_sum[ACC_W] : (acc_ovf | acc_sum[ACC_W]);
          out_valid <= 1'b1;
          state     <= IDLE;
          in_ready  <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule
